// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access path: operation encoding,
// machine-level CSR addresses and small decode helpers.
package csr_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        CSR_RW    = 3'd0,
        CSR_RS    = 3'd1,
        CSR_RC    = 3'd2,
        CSR_ECALL = 3'd3,
        CSR_MRET  = 3'd4
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    function automatic logic csr_is_rmw(input csr_op_t op);
        return (op == CSR_RW) || (op == CSR_RS) || (op == CSR_RC);
    endfunction

    // Writes to these change translation, privilege or trap state, so the
    // pipeline must refetch from the next instruction.
    function automatic logic csr_needs_redirect(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_SATP) || (addr == CSR_MTVEC);
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Execute-stage request and writeback response channel of the CSR unit.
interface csr_unit_if;
    import csr_pkg::*;

    logic            req_valid;
    logic            req_ready;
    csr_op_t         req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_src;
    logic            req_src_zero;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_pc;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic            resp_redirect;
    logic [XLEN-1:0] resp_redirect_pc;

    modport master (
        output req_valid, req_op, req_addr, req_src, req_src_zero, req_rd, req_pc,
        output flush, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_redirect, resp_redirect_pc
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_src_zero, req_rd, req_pc,
        input  flush, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_redirect, resp_redirect_pc
    );

endinterface

// File: rtl/csr_alu.sv
// Read-modify-write datapath: new CSR value and whether a write happens at all.
module csr_alu
    import csr_pkg::*;
(
    input  csr_op_t         op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    output logic [XLEN-1:0] wdata,
    output logic            do_write
);

    // Set/clear with a zero source must not write, so read-only CSRs can be read safely.
    always_comb begin
        wdata    = 64'd0;
        do_write = 1'b0;
        case (op)
            CSR_RW: begin
                wdata    = src;
                do_write = 1'b1;
            end
            CSR_RS: begin
                wdata    = old | src;
                do_write = ~src_zero;
            end
            CSR_RC: begin
                wdata    = old & ~src;
                do_write = ~src_zero;
            end
            default: begin
                wdata    = 64'd0;
                do_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_unit.sv
// CSR access sequencer: IDLE -> READ -> WRITE -> RESP, one op in flight.
// WRITE is the commit point; flush only kills an op still in READ.
module csr_unit
    import csr_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    csr_unit_if.slave       bus,
    output logic [11:0]     csr_addr_read,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_addr_write,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_we,
    output logic            csr_ecall,
    output logic            csr_mret,
    output logic [XLEN-1:0] csr_pc,
    input  logic [XLEN-1:0] csr_next_pc
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    csr_op_t         op_q, op_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            src_zero_q, src_zero_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            do_write_q, do_write_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] target_q, target_d;

    logic [XLEN-1:0] alu_wdata_s;
    logic            alu_do_write_s;
    logic            rmw_s;

    assign rmw_s = csr_is_rmw(op_q);

    csr_alu u_alu (
        .op       (op_q),
        .old      (csr_rdata),
        .src      (src_q),
        .src_zero (src_zero_q),
        .wdata    (alu_wdata_s),
        .do_write (alu_do_write_s)
    );

    // Next-state and datapath capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        old_d      = old_q;
        wdata_d    = wdata_q;
        do_write_d = do_write_q;
        redirect_d = redirect_q;
        target_d   = target_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d       = bus.req_op;
                    addr_d     = bus.req_addr;
                    src_d      = bus.req_src;
                    src_zero_d = bus.req_src_zero;
                    rd_d       = bus.req_rd;
                    pc_d       = bus.req_pc;
                    state_d    = ST_READ;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_READ: begin
                old_d      = csr_rdata;
                wdata_d    = alu_wdata_s;
                do_write_d = alu_do_write_s;
                state_d    = bus.flush ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                redirect_d = !rmw_s || (do_write_q && csr_needs_redirect(addr_q));
                target_d   = rmw_s ? (pc_q + 64'd4) : csr_next_pc;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = bus.resp_ready ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= CSR_RW;
            addr_q     <= 12'd0;
            src_q      <= 64'd0;
            src_zero_q <= 1'b0;
            rd_q       <= 5'd0;
            pc_q       <= 64'd0;
            old_q      <= 64'd0;
            wdata_q    <= 64'd0;
            do_write_q <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            old_q      <= old_d;
            wdata_q    <= wdata_d;
            do_write_q <= do_write_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    // Output decode; strobes are masked by reset so a reset in WRITE commits nothing.
    always_comb begin
        bus.req_ready        = (state_q == ST_IDLE);
        csr_addr_read        = (state_q == ST_READ) ? addr_q : 12'd0;
        csr_we               = (state_q == ST_WRITE) && do_write_q && !reset;
        csr_addr_write       = ((state_q == ST_WRITE) && rmw_s) ? addr_q : 12'd0;
        csr_wdata            = ((state_q == ST_WRITE) && rmw_s) ? wdata_q : 64'd0;
        csr_ecall            = (state_q == ST_WRITE) && (op_q == CSR_ECALL) && !reset;
        csr_mret             = (state_q == ST_WRITE) && (op_q == CSR_MRET) && !reset;
        csr_pc               = ((state_q == ST_WRITE) && (op_q == CSR_ECALL)) ? pc_q : 64'd0;
        bus.resp_valid       = (state_q == ST_RESP);
        bus.resp_rdata       = ((state_q == ST_RESP) && rmw_s) ? old_q : 64'd0;
        bus.resp_rd          = ((state_q == ST_RESP) && rmw_s) ? rd_q : 5'd0;
        bus.resp_redirect    = (state_q == ST_RESP) && redirect_q;
        bus.resp_redirect_pc = ((state_q == ST_RESP) && redirect_q) ? target_q : 64'd0;
    end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a small CSR register file plus an associative-array
// reference model predicting every strobe and response.
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] csr_addr_read, csr_addr_write;
    logic [63:0] csr_rdata, csr_wdata, csr_pc, csr_next_pc;
    logic        csr_we, csr_ecall, csr_mret;

    int n_checks = 0;
    int n_errs   = 0;
    int we_cnt   = 0;
    int trap_cnt = 0;
    int multi_hot = 0;

    csr_unit_if bus ();

    csr_unit dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .csr_addr_read  (csr_addr_read),
        .csr_rdata      (csr_rdata),
        .csr_addr_write (csr_addr_write),
        .csr_wdata      (csr_wdata),
        .csr_we         (csr_we),
        .csr_ecall      (csr_ecall),
        .csr_mret       (csr_mret),
        .csr_pc         (csr_pc),
        .csr_next_pc    (csr_next_pc)
    );

    always #5 clk = ~clk;

    // Register file: 0 mstatus, 1 mie, 2 mtvec, 3 mscratch, 4 mepc, 5 satp.
    logic [63:0] rf [0:5];

    function automatic int rf_idx(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:  return 0;
            CSR_MIE:      return 1;
            CSR_MTVEC:    return 2;
            CSR_MSCRATCH: return 3;
            CSR_MEPC:     return 4;
            CSR_SATP:     return 5;
            default:      return -1;
        endcase
    endfunction

    always_comb begin
        csr_rdata = 64'd0;
        if (rf_idx(csr_addr_read) >= 0) csr_rdata = rf[rf_idx(csr_addr_read)];
        csr_next_pc = csr_mret ? rf[4] : rf[2];
    end

    always @(posedge clk) begin
        if (csr_we && rf_idx(csr_addr_write) >= 0) rf[rf_idx(csr_addr_write)] <= csr_wdata;
        if (csr_ecall) rf[4] <= csr_pc;
        if (csr_we) we_cnt <= we_cnt + 1;
        if (csr_ecall || csr_mret) trap_cnt <= trap_cnt + 1;
        if ((32'(csr_we) + 32'(csr_ecall) + 32'(csr_mret)) > 32'd1) multi_hot <= multi_hot + 1;
    end

    // Reference model of architectural CSR contents.
    logic [63:0] mdl [logic [11:0]];

    function automatic logic [63:0] mdl_rd(input logic [11:0] a);
        return mdl.exists(a) ? mdl[a] : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_strobes", {59'd0, bus.resp_valid, csr_we, csr_ecall, csr_mret, bus.resp_redirect}, 64'd0);
        chk("rst_addrs", {35'd0, csr_addr_read, csr_addr_write, bus.resp_rd}, 64'd0);
        chk("rst_wdata", csr_wdata, 64'd0);
        chk("rst_csr_pc", csr_pc, 64'd0);
        chk("rst_rdata", bus.resp_rdata, 64'd0);
        chk("rst_rpc", bus.resp_redirect_pc, 64'd0);
    endtask

    // flush_at: 0 none, 1 during READ, 2 during WRITE.
    task automatic do_op(input csr_op_t op, input logic [11:0] addr, input logic [63:0] src,
                         input logic sz, input logic [4:0] rd, input logic [63:0] pc,
                         input int flush_at, input int stall, input logic rst_in_write);
        logic [63:0] old, nv, tgt, exp_rdata;
        logic        wr, redir, rmw;
        logic [4:0]  exp_rd;
        int          we0, tr0;
        rmw = (op == CSR_RW) || (op == CSR_RS) || (op == CSR_RC);
        old = mdl_rd(addr);
        nv = 64'd0; wr = 1'b0; redir = 1'b0; tgt = 64'd0;
        if (op == CSR_RW) begin nv = src; wr = 1'b1; end
        if (op == CSR_RS) begin nv = old | src; wr = !sz; end
        if (op == CSR_RC) begin nv = old & ~src; wr = !sz; end
        if (rmw && wr && (addr == CSR_MSTATUS || addr == CSR_SATP || addr == CSR_MTVEC)) begin
            redir = 1'b1; tgt = pc + 64'd4;
        end
        if (op == CSR_ECALL) begin redir = 1'b1; tgt = mdl_rd(CSR_MTVEC); end
        if (op == CSR_MRET)  begin redir = 1'b1; tgt = mdl_rd(CSR_MEPC); end
        exp_rdata = rmw ? old : 64'd0;
        exp_rd    = rmw ? rd : 5'd0;
        we0 = we_cnt; tr0 = trap_cnt;

        @(negedge clk);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_src = src;
        bus.req_src_zero = sz; bus.req_rd = rd; bus.req_pc = pc;
        bus.flush = (flush_at == 1) && ($urandom_range(0, 1) == 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        chk("read_busy", 64'(bus.req_ready), 64'd0);
        chk("read_addr", 64'(csr_addr_read), 64'(addr));
        if (flush_at == 1) begin
            bus.flush = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.flush = 1'b0;
            chk("flush_ready", 64'(bus.req_ready), 64'd1);
            chk("flush_resp", 64'(bus.resp_valid), 64'd0);
            @(posedge clk);
            chk("flush_no_side", 64'(we_cnt - we0 + trap_cnt - tr0), 64'd0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (flush_at == 2) bus.flush = 1'b1;
        if (rst_in_write) begin
            reset = 1'b1;
            #1;
            chk("rstw_we", {61'd0, csr_we, csr_ecall, csr_mret}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            chk_reset_outputs();
            chk("rstw_no_write", 64'(we_cnt - we0 + trap_cnt - tr0), 64'd0);
            return;
        end
        chk("write_we", 64'(csr_we), 64'(wr));
        chk("write_ecall", 64'(csr_ecall), 64'(op == CSR_ECALL));
        chk("write_mret", 64'(csr_mret), 64'(op == CSR_MRET));
        if (wr) begin
            chk("write_addr", 64'(csr_addr_write), 64'(addr));
            chk("write_data", csr_wdata, nv);
            if (mdl.exists(addr)) mdl[addr] = nv;
        end
        if (op == CSR_ECALL) begin
            chk("ecall_pc", csr_pc, pc);
            mdl[CSR_MEPC] = pc;
        end
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk("resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("resp_busy", 64'(bus.req_ready), 64'd0);
            chk("resp_rdata", bus.resp_rdata, exp_rdata);
            chk("resp_rd", 64'(bus.resp_rd), 64'(exp_rd));
            chk("resp_redirect", 64'(bus.resp_redirect), 64'(redir));
            if (redir) chk("resp_target", bus.resp_redirect_pc, tgt);
            if (i < stall) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("done_idle", {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
        chk("strobe_count", 64'(we_cnt - we0), 64'(wr));
    endtask

    logic [11:0] addrs [0:7];

    initial begin
        addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_SATP, 12'h7C0, CSR_MSCRATCH};
        rf = '{64'd0, 64'hF0, 64'h8000_0100, 64'd0, 64'h8000_0044, 64'd0};
        mdl[CSR_MSTATUS] = 64'd0;            mdl[CSR_MIE]  = 64'hF0;
        mdl[CSR_MTVEC]   = 64'h8000_0100;    mdl[CSR_MSCRATCH] = 64'd0;
        mdl[CSR_MEPC]    = 64'h8000_0044;    mdl[CSR_SATP] = 64'd0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = CSR_RW; bus.req_addr = 12'd0; bus.req_src = 64'd0;
        bus.req_src_zero = 1'b0; bus.req_rd = 5'd0; bus.req_pc = 64'd0;
        bus.flush = 1'b0; bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;

        do_op(CSR_RW, CSR_MSCRATCH, 64'hDEAD, 1'b0, 5'd5, 64'h100, 0, 0, 1'b0);
        do_op(CSR_RS, CSR_MIE, 64'h0F, 1'b0, 5'd6, 64'h104, 0, 0, 1'b0);
        do_op(CSR_RC, CSR_MIE, 64'h30, 1'b0, 5'd7, 64'h108, 0, 0, 1'b0);
        do_op(CSR_RS, CSR_MIE, 64'h0, 1'b1, 5'd8, 64'h10C, 0, 0, 1'b0);
        do_op(CSR_MRET, 12'd0, 64'd0, 1'b1, 5'd0, 64'h200, 0, 0, 1'b0);
        do_op(CSR_ECALL, 12'd0, 64'd0, 1'b1, 5'd0, 64'h8000_0040, 0, 0, 1'b0);
        do_op(CSR_RW, CSR_MTVEC, 64'h9000_0000, 1'b0, 5'd1, 64'h300, 1, 0, 1'b0);
        do_op(CSR_RW, CSR_MSCRATCH, 64'h1234, 1'b0, 5'd2, 64'h304, 2, 0, 1'b0);
        do_op(CSR_RW, CSR_MSTATUS, 64'h8, 1'b0, 5'd3, 64'h400, 0, 5, 1'b0);
        do_op(CSR_RW, CSR_MSCRATCH, 64'h5555, 1'b0, 5'd4, 64'h408, 0, 0, 1'b1);
        do_op(CSR_RS, CSR_MSCRATCH, 64'h0, 1'b1, 5'd9, 64'h40C, 0, 0, 1'b0);
        do_op(CSR_RW, 12'h7C0, 64'hABCD, 1'b0, 5'd0, 64'h410, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            csr_op_t     op;
            logic        sz;
            logic [63:0] src;
            int          f;
            op  = csr_op_t'($urandom_range(0, 4));
            sz  = ($urandom_range(0, 3) == 0);
            src = sz ? 64'd0 : {$urandom, $urandom};
            f   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_op(op, addrs[$urandom_range(0, 7)], src, sz, 5'($urandom), {$urandom, $urandom},
                  f, int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
        end

        chk("one_hot_strobes", 64'(multi_hot), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
